// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state and bus-owner encodings, plus a
// helper that sizes the starvation counter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OwnI = 1'b0,
    OwnD = 1'b1
  } arb_owner_e;

  // Bits needed to hold 0..lim inclusive.
  function automatic int unsigned cnt_width(input int unsigned lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive D grants taken while a fetch was waiting.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   inc      : D granted while i_req pending (saturates at STARVE_LIM)
//   clr      : I granted (has priority over inc)
//   at_lim   : count == STARVE_LIM, fetch must win the next collision
module arb_starve_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_lim
);

  localparam int unsigned CW = cnt_width(STARVE_LIM);
  localparam logic [CW-1:0] LimVal = CW'(STARVE_LIM);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LimVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_lim = (cnt_q == LimVal);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between the fetch port (I) and the mem-stage
// data port (D). One transaction at a time: grant -> issue -> wait -> respond.
// D wins collisions unless fetch has been passed over STARVE_LIM times in a row.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   i_req/i_addr -> i_rdata/i_ack    : fetch requester (ack is a one-cycle pulse)
//   d_req/d_we/d_be/d_addr/d_wdata   : data requester
//   d_rdata/d_ack                    : load data (held) and one-cycle completion pulse
//   m_req/m_we/m_be/m_addr/m_wdata   : memory request, held until m_ready
//   m_ready, m_rvalid, m_rdata       : memory handshake and response
//   busy                             : arbiter not idle
// All outputs are registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_ready,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            busy
);

  localparam int unsigned BW = DW / 8;

  arb_state_e state_q;
  arb_owner_e owner_q;

  logic at_lim;
  logic grant_d;
  logic idle_req;
  logic starve_inc;
  logic starve_clr;

  // D wins unless fetch is also waiting and has hit the starvation limit.
  assign grant_d    = d_req && !(i_req && at_lim);
  assign idle_req   = (state_q == StIdle) && (i_req || d_req);
  assign starve_inc = idle_req && grant_d && i_req;
  assign starve_clr = idle_req && !grant_d;

  arb_starve_cnt #(
    .STARVE_LIM (STARVE_LIM)
  ) u_starve_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_lim (at_lim)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OwnI;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_be    <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_req || d_req) begin
            owner_q <= grant_d ? OwnD : OwnI;
            m_req   <= 1'b1;
            m_addr  <= grant_d ? d_addr : i_addr;
            m_we    <= grant_d && d_we;
            // Fetches and loads read the full word.
            m_be    <= (grant_d && d_we) ? d_be : {BW{1'b1}};
            m_wdata <= grant_d ? d_wdata : '0;
            busy    <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (m_ready) begin
            m_req   <= 1'b0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (m_rvalid) begin
            if (owner_q == OwnI) begin
              i_rdata <= m_rdata;
              i_ack   <= 1'b1;
            end else begin
              // Stores leave the last load data untouched.
              if (!m_we) begin
                d_rdata <= m_rdata;
              end
              d_ack <= 1'b1;
            end
            state_q <= StResp;
          end
        end
        StResp: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_ack, d_req, d_we, d_ack;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, m_be;
  logic        m_req, m_we, m_ready, m_rvalid, busy;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .STARVE_LIM (LIM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ack    (i_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_be     (d_be),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_be     (m_be),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ready  (m_ready),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .busy     (busy)
  );

  typedef struct {
    logic ir; logic [31:0] ia;
    logic dr; logic dw; logic [3:0] db; logic [31:0] da; logic [31:0] dwd;
    logic mr; logic mv; logic [31:0] md;
    logic emr; logic ewe; logic [3:0] ebe; logic [31:0] ea; logic [31:0] ewd;
    logic eia; logic eda; logic eb; logic [31:0] eir; logic [31:0] edr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                             input logic [3:0] db, input logic [31:0] da, input logic [31:0] dwd,
                             input logic mr, input logic mv, input logic [31:0] md,
                             input logic emr, input logic ewe, input logic [3:0] ebe,
                             input logic [31:0] ea, input logic [31:0] ewd, input logic eia,
                             input logic eda, input logic eb, input logic [31:0] eir,
                             input logic [31:0] edr);
    vec_t r;
    r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw; r.db = db; r.da = da; r.dwd = dwd;
    r.mr = mr; r.mv = mv; r.md = md;
    r.emr = emr; r.ewe = ewe; r.ebe = ebe; r.ea = ea; r.ewd = ewd;
    r.eia = eia; r.eda = eda; r.eb = eb; r.eir = eir; r.edr = edr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0;
    d_wdata = '0; m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, {59'd0, m_req, m_we, i_ack, d_ack, busy}, 64'd0);
    chk({tag, "_m_be"}, {60'd0, m_be}, 64'd0);
    chk({tag, "_m_addr"}, {32'd0, m_addr}, 64'd0);
    chk({tag, "_m_wdata"}, {32'd0, m_wdata}, 64'd0);
    chk({tag, "_i_rdata"}, {32'd0, i_rdata}, 64'd0);
    chk({tag, "_d_rdata"}, {32'd0, d_rdata}, 64'd0);
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Wait for m_req, accept at once, respond next cycle, then sample the ack cycle.
  task automatic serve(output logic got_i, output logic got_d, output logic [31:0] got_addr);
    int t = 0;
    while (!m_req && t < 20) begin
      cyc();
      t++;
    end
    chk("serve_mreq", {63'd0, m_req}, 64'd1);
    got_addr = m_addr;
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    m_rvalid = 1'b1;
    m_rdata = $urandom;
    cyc();
    m_rvalid = 1'b0;
    got_i = i_ack;
    got_d = d_ack;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        gi, gd, gdx;
    logic [31:0] ga;
    int          t_grant, t_acc, t_rv, t_ack, free_at, starve, rd, vd;
    bit          ip, dp, own_d, tx_we, e_mreq;
    logic [31:0] tx_addr, tx_wdata, cap, ex_ird, ex_drd;
    logic [3:0]  tx_be;

    // ---- reset values, then reset abandoned mid-WAIT ----
    do_reset();
    chk_reset_outs("por");
    d_req = 1'b1; d_addr = 32'h44; d_we = 1'b0;
    cyc();
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset_outs("rst_wait");
    d_req = 1'b0;
    cyc();
    rst = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hDEAD;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("post_rst_ctl", {61'd0, i_ack, d_ack, busy}, 64'd0);
      chk("post_rst_rdata", {i_rdata, d_rdata}, 64'd0);
    end
    m_rvalid = 1'b0;

    // ---- table: fetch, collision, delayed store, spurious handshakes ----
    vecs.push_back(v(1, 32'h400000, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 32'h400000, 0, 0, 4'h0, 0, 0, 1, 0, 0,
                     1, 0, 4'hF, 32'h400000, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(1, 32'h400000, 0, 0, 4'h0, 0, 0, 0, 1, 32'h20080005,
                     0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(1, 32'h400000, 0, 0, 4'h0, 0, 0, 0, 0, 0,
                     0, 0, 4'h0, 0, 0, 1, 0, 1, 32'h20080005, 0));
    vecs.push_back(v(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 32'h20080005, 0));
    vecs.push_back(v(1, 32'h400004, 1, 0, 4'h0, 32'h10, 0, 0, 0, 0,
                     0, 0, 4'h0, 0, 0, 0, 0, 0, 32'h20080005, 0));
    vecs.push_back(v(1, 32'h400004, 1, 0, 4'h0, 32'h10, 0, 1, 0, 0,
                     1, 0, 4'hF, 32'h10, 0, 0, 0, 1, 32'h20080005, 0));
    vecs.push_back(v(1, 32'h400004, 1, 0, 4'h0, 32'h10, 0, 0, 1, 32'h11112222,
                     0, 0, 4'h0, 0, 0, 0, 0, 1, 32'h20080005, 0));
    vecs.push_back(v(1, 32'h400004, 1, 0, 4'h0, 32'h10, 0, 0, 0, 0,
                     0, 0, 4'h0, 0, 0, 0, 1, 1, 32'h20080005, 32'h11112222));
    vecs.push_back(v(1, 32'h400004, 0, 0, 4'h0, 0, 0, 0, 0, 0,
                     0, 0, 4'h0, 0, 0, 0, 0, 0, 32'h20080005, 32'h11112222));
    vecs.push_back(v(1, 32'h400100, 0, 0, 4'h0, 0, 0, 1, 0, 0,
                     1, 0, 4'hF, 32'h400004, 0, 0, 0, 1, 32'h20080005, 32'h11112222));
    vecs.push_back(v(1, 32'h400100, 0, 0, 4'h0, 0, 0, 0, 1, 32'h33334444,
                     0, 0, 4'h0, 0, 0, 0, 0, 1, 32'h20080005, 32'h11112222));
    vecs.push_back(v(1, 32'h400100, 0, 0, 4'h0, 0, 0, 0, 0, 0,
                     0, 0, 4'h0, 0, 0, 1, 0, 1, 32'h33334444, 32'h11112222));
    vecs.push_back(v(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0,
                     0, 0, 4'h0, 0, 0, 0, 0, 0, 32'h33334444, 32'h11112222));
    vecs.push_back(v(0, 0, 1, 1, 4'h3, 32'h20, 32'hCAFEBABE, 0, 0, 0,
                     0, 0, 4'h0, 0, 0, 0, 0, 0, 32'h33334444, 32'h11112222));
    vecs.push_back(v(0, 0, 1, 1, 4'hF, 32'h99, 0, 0, 1, 32'hDEAD,
                     1, 1, 4'h3, 32'h20, 32'hCAFEBABE, 0, 0, 1, 32'h33334444, 32'h11112222));
    vecs.push_back(v(0, 0, 1, 1, 4'hF, 32'h99, 0, 0, 0, 0,
                     1, 1, 4'h3, 32'h20, 32'hCAFEBABE, 0, 0, 1, 32'h33334444, 32'h11112222));
    vecs.push_back(v(0, 0, 1, 1, 4'h3, 32'h20, 32'hCAFEBABE, 0, 0, 0,
                     1, 1, 4'h3, 32'h20, 32'hCAFEBABE, 0, 0, 1, 32'h33334444, 32'h11112222));
    vecs.push_back(v(0, 0, 1, 1, 4'h3, 32'h20, 32'hCAFEBABE, 1, 0, 0,
                     1, 1, 4'h3, 32'h20, 32'hCAFEBABE, 0, 0, 1, 32'h33334444, 32'h11112222));
    vecs.push_back(v(0, 0, 1, 1, 4'h3, 32'h20, 32'hCAFEBABE, 0, 0, 0,
                     0, 0, 4'h0, 0, 0, 0, 0, 1, 32'h33334444, 32'h11112222));
    vecs.push_back(v(0, 0, 1, 1, 4'h3, 32'h20, 32'hCAFEBABE, 0, 1, 32'hDEADBEEF,
                     0, 0, 4'h0, 0, 0, 0, 0, 1, 32'h33334444, 32'h11112222));
    vecs.push_back(v(0, 0, 1, 1, 4'h3, 32'h20, 32'hCAFEBABE, 0, 0, 0,
                     0, 0, 4'h0, 0, 0, 0, 1, 1, 32'h33334444, 32'h11112222));
    vecs.push_back(v(0, 0, 0, 0, 4'h0, 0, 0, 1, 1, 32'h5555,
                     0, 0, 4'h0, 0, 0, 0, 0, 0, 32'h33334444, 32'h11112222));
    vecs.push_back(v(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0,
                     0, 0, 4'h0, 0, 0, 0, 0, 0, 32'h33334444, 32'h11112222));

    foreach (vecs[k]) begin
      cyc();
      i_req = vecs[k].ir; i_addr = vecs[k].ia; d_req = vecs[k].dr; d_we = vecs[k].dw;
      d_be = vecs[k].db; d_addr = vecs[k].da; d_wdata = vecs[k].dwd;
      m_ready = vecs[k].mr; m_rvalid = vecs[k].mv; m_rdata = vecs[k].md;
      chk($sformatf("vec%0d_ctl", k), {60'd0, m_req, i_ack, d_ack, busy},
          {60'd0, vecs[k].emr, vecs[k].eia, vecs[k].eda, vecs[k].eb});
      if (vecs[k].emr) begin
        chk($sformatf("vec%0d_m_addr", k), {32'd0, m_addr}, {32'd0, vecs[k].ea});
        chk($sformatf("vec%0d_we_be", k), {59'd0, m_we, m_be}, {59'd0, vecs[k].ewe, vecs[k].ebe});
        if (vecs[k].ewe) begin
          chk($sformatf("vec%0d_m_wdata", k), {32'd0, m_wdata}, {32'd0, vecs[k].ewd});
        end
      end
      chk($sformatf("vec%0d_rdata", k), {i_rdata, d_rdata}, {vecs[k].eir, vecs[k].edr});
    end

    // ---- starvation: both held, D wins four times, then I, then D ----
    do_reset();
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_addr = 32'h200; d_we = 1'b0;
    for (int g = 0; g < 6; g++) begin
      gdx = (g != 4);
      serve(gi, gd, ga);
      chk($sformatf("starve%0d_addr", g), {32'd0, ga}, {32'd0, gdx ? 32'h200 : 32'h100});
      chk($sformatf("starve%0d_ack", g), {62'd0, gi, gd}, {62'd0, !gdx, gdx});
    end

    // ---- randomized traffic against a timeline model ----
    do_reset();
    t_grant = -100; t_acc = -100; t_rv = -100; t_ack = -100; free_at = 0; starve = 0;
    ip = 0; dp = 0; own_d = 0; tx_we = 0; tx_addr = '0; tx_wdata = '0; tx_be = '0;
    cap = '0; ex_ird = '0; ex_drd = '0;
    for (int n = 0; n < 800; n++) begin
      cyc();
      if (n == t_ack) begin
        if (own_d) begin
          if (!tx_we) ex_drd = cap;
          dp = 0; d_req = 1'b0;
        end else begin
          ex_ird = cap;
          ip = 0; i_req = 1'b0;
        end
      end
      e_mreq = (n > t_grant) && (n <= t_acc);
      chk("rnd_ctl", {60'd0, m_req, busy, i_ack, d_ack},
          {60'd0, e_mreq, (n > t_grant) && (n <= t_ack), (n == t_ack) && !own_d,
           (n == t_ack) && own_d});
      if (e_mreq) begin
        chk("rnd_m_addr", {32'd0, m_addr}, {32'd0, tx_addr});
        chk("rnd_we_be", {59'd0, m_we, m_be}, {59'd0, tx_we, tx_be});
        if (tx_we) chk("rnd_m_wdata", {32'd0, m_wdata}, {32'd0, tx_wdata});
      end
      chk("rnd_rdata", {i_rdata, d_rdata}, {ex_ird, ex_drd});

      // Requesters: raise new requests, occasionally disturb pending operands.
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
      end

      // Arbitration opportunity.
      if (n == free_at) begin
        if (ip || dp) begin
          gdx = dp && !(ip && starve == LIM);
          if (gdx && ip) starve = (starve < LIM) ? starve + 1 : LIM;
          else if (!gdx) starve = 0;
          own_d = gdx;
          tx_addr = gdx ? d_addr : i_addr;
          tx_we = gdx && d_we;
          tx_be = tx_we ? d_be : 4'hF;
          tx_wdata = d_wdata;
          rd = $urandom_range(0, 3);
          vd = $urandom_range(0, 3);
          t_grant = n; t_acc = n + 1 + rd; t_rv = t_acc + 1 + vd; t_ack = t_rv + 1;
          free_at = t_ack + 1;
        end else begin
          free_at = n + 1;
        end
      end

      // Memory: real handshakes on schedule, spurious ones wherever they must be ignored.
      if (n == t_acc) m_ready = 1'b1;
      else if (n <= t_grant || n > t_acc) m_ready = ($urandom_range(0, 3) == 0);
      else m_ready = 1'b0;
      if (n == t_rv) m_rvalid = 1'b1;
      else if (n <= t_acc || n > t_rv) m_rvalid = ($urandom_range(0, 3) == 0);
      else m_rvalid = 1'b0;
      m_rdata = $urandom;
      if (n == t_rv) cap = m_rdata;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
